// File: rtl/cic_interp_hs.sv
// CIC interpolator: input-rate combs, zero-stuff by a runtime power-of-two R,
// output-rate integrators, exact R^(N-1) gain removal, ce gating and input handshake.
module cic_interp_hs #(
    parameter int STAGES        = 3,
    parameter int IN_WIDTH      = 16,
    parameter int OUT_WIDTH     = 16,
    parameter int MAX_RATE_LOG2 = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clr_i,
    input  logic                                 ce_i,
    input  logic [$clog2(MAX_RATE_LOG2+1)-1:0]   rate_log2_i,
    input  logic [IN_WIDTH-1:0]                  in_data_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    output logic [OUT_WIDTH-1:0]                 out_data_o,
    output logic                                 out_valid_o,
    output logic                                 underrun_o
);
    localparam int IW  = IN_WIDTH + STAGES * MAX_RATE_LOG2;
    localparam int RLW = $clog2(MAX_RATE_LOG2 + 1);
    localparam int PW  = MAX_RATE_LOG2;

    logic [PW-1:0]              phase_q, phase_d;
    logic [PW:0]                phase_inc;
    logic [RLW-1:0]             r_act_q, rate_clamp, r_eff;
    logic                       phase_zero, accept, slot_q;
    logic [IW-1:0]              x, u, prev, comb_reg_q;
    logic [STAGES-1:0][IW-1:0]  d_q, c, integ_q;
    logic signed [IW-1:0]       norm;
    logic [7:0]                 shamt;
    logic [OUT_WIDTH-1:0]       out_d, out_data_q;
    logic                       out_valid_q, underrun_q;

    always_comb begin
        rate_clamp = (rate_log2_i > RLW'(MAX_RATE_LOG2)) ? RLW'(MAX_RATE_LOG2) : rate_log2_i;
        phase_zero = (phase_q == '0);
        // A new rate is only sampled at the block boundary (phase 0).
        r_eff      = phase_zero ? rate_clamp : r_act_q;
        phase_inc  = {1'b0, phase_q} + (PW+1)'(1);
        phase_d    = ((phase_inc >> r_eff) != '0) ? '0 : phase_inc[PW-1:0];
        in_ready_o = ce_i & phase_zero;
        accept     = in_ready_o & in_valid_i;
        x          = accept ? {{(IW-IN_WIDTH){in_data_i[IN_WIDTH-1]}}, in_data_i} : '0;
        prev       = x;
        for (int j = 0; j < STAGES; j++) begin
            c[j] = prev - d_q[j];
            prev = c[j];
        end
        u          = slot_q ? comb_reg_q : '0;
        shamt      = 8'((STAGES - 1) * int'(r_act_q));
        norm       = $signed(integ_q[STAGES-1]) >>> shamt;
        out_d      = OUT_WIDTH'(norm >>> (IN_WIDTH - OUT_WIDTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= '0;
            r_act_q     <= '0;
            slot_q      <= 1'b0;
            d_q         <= '0;
            comb_reg_q  <= '0;
            integ_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else if (clr_i) begin
            phase_q     <= '0;
            r_act_q     <= '0;
            slot_q      <= 1'b0;
            d_q         <= '0;
            comb_reg_q  <= '0;
            integ_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            out_valid_q <= ce_i;
            if (ce_i) begin
                phase_q <= phase_d;
                slot_q  <= phase_zero;
                if (phase_zero) begin
                    r_act_q    <= rate_clamp;
                    d_q[0]     <= x;
                    for (int j = 1; j < STAGES; j++) d_q[j] <= c[j-1];
                    comb_reg_q <= c[STAGES-1];
                    if (!in_valid_i) underrun_q <= 1'b1;
                end
                // Each integrator consumes the previous stage's registered value.
                integ_q[0] <= integ_q[0] + u;
                for (int k = 1; k < STAGES; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
                out_data_q <= out_d;
            end
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign underrun_o  = underrun_q;
endmodule

// File: tb/tb_cic_interp_hs.sv
// Bench for cic_interp_hs: reference model is the zero-stuffed input convolved
// with the N-fold boxcar of length R, delayed N+1 ce ticks, scaled by R^-(N-1).
module tb_cic_interp_hs;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst, clr, ce, in_valid;
    logic [2:0]  rate_log2;
    logic [15:0] in_data;
    logic        in_ready, out_valid, underrun;
    logic [15:0] out_data;

    cic_interp_hs #(.STAGES(N), .IN_WIDTH(16), .OUT_WIDTH(16), .MAX_RATE_LOG2(4)) dut (
        .clk(clk), .rst(rst), .clr_i(clr), .ce_i(ce), .rate_log2_i(rate_log2),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    longint xup[$];
    longint h[$];
    int     m_r;
    logic   m_und;
    longint m_out;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        rdy;
        longint      out;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear(input int r);
        longint a[$];
        longint b[$];
        int     rr;
        m_r = r;
        rr  = 1 << r;
        xup.delete();
        m_und = 1'b0;
        m_out = 0;
        a = '{1};
        for (int s = 0; s < N; s++) begin
            b.delete();
            for (int i = 0; i < a.size() + rr - 1; i++) begin
                longint acc = 0;
                for (int j = 0; j < rr; j++)
                    if (i - j >= 0 && i - j < a.size()) acc += a[i-j];
                b.push_back(acc);
            end
            a = b;
        end
        h = a;
    endfunction

    function automatic void m_step(input logic v, input logic signed [15:0] d);
        int     n;
        bit     slot;
        longint y, ysh;
        logic signed [15:0] t;
        n    = xup.size();
        slot = (n % (1 << m_r)) == 0;
        xup.push_back((slot && v) ? longint'(d) : 0);
        if (slot && !v) m_und = 1'b1;
        y = 0;
        for (int k = 0; k < h.size(); k++) begin
            int idx = n - (N + 1) - k;
            if (idx >= 0) y += h[k] * xup[idx];
        end
        ysh   = y >>> ((N - 1) * m_r);
        t     = ysh[15:0];
        m_out = t;
    endfunction

    task automatic tick(input logic c, input logic v, input logic [15:0] d);
        bit exp_rdy;
        ce = c; in_valid = v; in_data = d;
        #1;
        exp_rdy = c && ((xup.size() % (1 << m_r)) == 0);
        check("in_ready", longint'(in_ready), longint'(exp_rdy));
        @(posedge clk); #1;
        if (c) m_step(v, d);
        check("out_valid", longint'(out_valid), longint'(c));
        check("out_data", longint'($signed(out_data)), m_out);
        check("underrun", longint'(underrun), longint'(m_und));
    endtask

    task automatic do_clr(input logic [2:0] rate);
        rate_log2 = rate; clr = 1'b1; ce = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        @(posedge clk); #1;
        clr = 1'b0; ce = 1'b0;
        model_clear((rate > 3'd4) ? 4 : int'(rate));
        check("clr_out_data", longint'(out_data), 0);
        check("clr_out_valid", longint'(out_valid), 0);
        check("clr_underrun", longint'(underrun), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        longint tap[10];
        longint isum;
        logic   exp_seq[12];
        logic [2:0] rates[6];

        tap = '{4, 12, 24, 40, 48, 48, 40, 24, 12, 4};
        for (int i = 0; i < 16; i++) begin
            tbl[i].v   = 1'b1;
            tbl[i].d   = (i == 0) ? 16'd64 : 16'd0;
            tbl[i].rdy = (i % 4) == 0;
            tbl[i].out = (i >= 4 && i < 14) ? tap[i-4] : 0;
        end
        exp_seq = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        rates   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

        rst = 1'b0; clr = 1'b0; ce = 1'b0; in_valid = 1'b0; in_data = '0; rate_log2 = 3'd2;
        #1 rst = 1'b1;
        #10;
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_underrun", longint'(underrun), 0);
        check("rst_in_ready_ce0", longint'(in_ready), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        model_clear(2);

        // DC settle: 1000 held at R=4
        do_clr(3'd2);
        for (int i = 0; i < 48; i++) tick(1'b1, 1'b1, 16'd1000);
        check("dc_settled", longint'($signed(out_data)), 1000);

        // Impulse response table at R=4
        do_clr(3'd2);
        isum = 0;
        for (int i = 0; i < 16; i++) begin
            ce = 1'b1; in_valid = tbl[i].v; in_data = tbl[i].d;
            #1;
            check("imp_in_ready", longint'(in_ready), longint'(tbl[i].rdy));
            @(posedge clk); #1;
            check("imp_out", longint'($signed(out_data)), tbl[i].out);
            isum += longint'($signed(out_data));
        end
        check("imp_sum", isum, 64 * 4);

        // Async reset mid-stream, with underrun set and integrators loaded
        do_clr(3'd2);
        for (int i = 0; i < 6; i++) tick(1'b1, (i != 4), 16'd500);
        ce = 1'b0; in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_data", longint'(out_data), 0);
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_underrun", longint'(underrun), 0);
        check("midrst_in_ready", longint'(in_ready), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        model_clear(2);
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 16'd300);

        // Missed slot: zero-sample dip and sticky underrun, then clear
        do_clr(3'd2);
        for (int i = 0; i < 40; i++) tick(1'b1, (i != 12), 16'd1000);
        check("underrun_sticky", longint'(underrun), 1);
        do_clr(3'd2);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 16'd0);

        // ce every 3rd clock
        do_clr(3'd2);
        for (int i = 0; i < 90; i++) tick((i % 3) == 0, 1'b1, (i < 45) ? 16'd1000 : 16'hFC18);

        // Rate change 1 -> 3 at phase 1 takes effect at the next phase 0
        do_clr(3'd1);
        for (int i = 0; i < 12; i++) begin
            rate_log2 = (i == 0) ? 3'd1 : 3'd3;
            ce = 1'b1; in_valid = 1'b1; in_data = '0;
            #1;
            check("ratechg_in_ready", longint'(in_ready), longint'(exp_seq[i]));
            @(posedge clk); #1;
        end

        // Randomized traffic at each rate, including a clamped one
        for (int r = 0; r < 6; r++) begin
            do_clr(rates[r]);
            for (int i = 0; i < 120; i++)
                tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
